// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture path: state encoding and default sizing.
`timescale 1ns/1ps
package i2s_pkg;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam int DEF_BITSIZE   = 24;
  // clk must run at least this many times faster than bclk for the oversampler
  localparam int MIN_CLK_RATIO = 4;

endpackage

// File: rtl/i2s_receiver_if.sv
// Pin-side and sample-side signals of the I2S receiver, bundled for port connection.
`timescale 1ns/1ps
interface i2s_receiver_if #(
  parameter int BITSIZE = i2s_pkg::DEF_BITSIZE
);

  logic               bclk;
  logic               lrclk;
  logic               sdin;
  logic [BITSIZE-1:0] out_l;
  logic [BITSIZE-1:0] out_r;
  logic               valid;
  logic               slot_err;

  // master: the codec side driving the serial pins and consuming samples
  modport master (
    output bclk, lrclk, sdin,
    input  out_l, out_r, valid, slot_err
  );

  modport slave (
    input  bclk, lrclk, sdin,
    output out_l, out_r, valid, slot_err
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus a one-clk rising-edge pulse.
`timescale 1ns/1ps
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [2:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples the previous stage's old value.
      ff <= {ff[1:0], d};
    end
  end

  assign q    = ff[1];
  assign rise = ff[1] & ~ff[2];

endmodule

// File: rtl/i2s_receiver.sv
// Oversampling I2S receiver: deserialises left/right slots into parallel words on clk.
`timescale 1ns/1ps
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int CNTSIZE = 6
) (
  input logic          clk,
  input logic          rst,
  i2s_receiver_if.slave bus
);

  localparam int                  IDXW   = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
  localparam logic [CNTSIZE-1:0]  BITS_C = CNTSIZE'(BITSIZE);

  logic               tick;
  logic               bclk_s;
  logic [1:0]         lr_ff;
  logic [1:0]         sd_ff;
  logic               lrclk_s;
  logic               sdin_s;

  state_t             state;
  logic               lrclk_prev;
  logic [BITSIZE-1:0] sr;
  logic [CNTSIZE-1:0] bitcnt;
  logic [BITSIZE-1:0] left_hold;
  logic [BITSIZE-1:0] out_l_q;
  logic [BITSIZE-1:0] out_r_q;
  logic               valid_q;
  logic               slot_err_q;

  logic [BITSIZE-1:0] sr_cap;
  logic [CNTSIZE-1:0] bitcnt_inc;
  logic [IDXW-1:0]    wr_idx;
  logic               short_slot;

  i2s_sync_edge u_bclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.bclk),
    .q    (bclk_s),
    .rise (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_ff <= '0;
      sd_ff <= '0;
    end else begin
      lr_ff <= {lr_ff[0], bus.lrclk};
      sd_ff <= {sd_ff[0], bus.sdin};
    end
  end

  assign lrclk_s = lr_ff[1];
  assign sdin_s  = sd_ff[1];

  // Shift register with the current bit written MSB-first; bits past BITSIZE are dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sr_cap = sr;
    wr_idx = IDXW'(BITSIZE - 1) - IDXW'(bitcnt);
    if (bitcnt < BITS_C) begin
      sr_cap[wr_idx] = sdin_s;
    end
  end

  assign bitcnt_inc = (&bitcnt) ? bitcnt : bitcnt + CNTSIZE'(1);
  // bitcnt_inc includes the boundary bit, so it is the full slot length
  assign short_slot = (bitcnt_inc < BITS_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEEK;
      lrclk_prev <= 1'b0;
      sr         <= '0;
      bitcnt     <= '0;
      left_hold  <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      valid_q    <= 1'b0;
      slot_err_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      slot_err_q <= 1'b0;
      if (tick) begin
        if (lrclk_s == lrclk_prev) begin
          sr     <= sr_cap;
          bitcnt <= bitcnt_inc;
        end else begin
          sr         <= '0;
          bitcnt     <= '0;
          lrclk_prev <= lrclk_s;
          unique case (state)
            SEEK: begin
              if (!lrclk_s) state <= LEFT;
            end
            LEFT: begin
              left_hold  <= sr_cap;
              slot_err_q <= short_slot;
              state      <= RIGHT;
            end
            RIGHT: begin
              out_l_q    <= left_hold;
              out_r_q    <= sr_cap;
              valid_q    <= 1'b1;
              slot_err_q <= short_slot;
              state      <= LEFT;
            end
            default: state <= SEEK;
          endcase
        end
      end
    end
  end

  assign bus.out_l    = out_l_q;
  assign bus.out_r    = out_r_q;
  assign bus.valid    = valid_q;
  assign bus.slot_err = slot_err_q;

endmodule
